// File: rtl/ct_fifo_pkg.sv
// Shared FIFO helpers: clog2 and the level/pointer width derivations.
// Future FIFO variants use these so their widths stay consistent.
package ct_fifo_pkg;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   // Occupancy counts 0..DEPTH inclusive, so it needs one bit more than the address.
   function automatic int level_width(input int depth);
      return clog2(depth) + 1;
   endfunction

   // The extra MSB tells full from empty when the address bits are equal.
   function automatic int ptr_width(input int depth);
      return clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/ct_fifo_ram.sv
// Simple dual-port storage: synchronous write, synchronous read (1 cycle), no read-during-write check.
// No backpressure; rdata holds its value whenever re is low.
module ct_fifo_ram
   import ct_fifo_pkg::*;
#(
   parameter int WIDTH    = 1,
   parameter int DEPTH    = 32,
   parameter     RAMSTYLE = "MLAB",
   localparam int AW      = clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic             re,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   (* ramstyle = RAMSTYLE *) logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ct_sync_fifo.sv
// Single-clock FIFO with registered head-of-queue output; first word visible 2 edges after push into empty.
// Valid/ready on both sides; o_ready is registered and low at full, even when a pop occurs on the same edge.
module ct_sync_fifo
   import ct_fifo_pkg::*;
#(
   parameter int WIDTH     = 1,
   parameter int DEPTH     = 32,
   parameter int AF_THRESH = 28,
   parameter int AE_THRESH = 4,
   parameter     RAMSTYLE  = "MLAB",
   localparam int LW       = level_width(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             i_flush,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_valid,
   output logic             o_ready,
   output logic [WIDTH-1:0] o_data,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [LW-1:0]    o_level,
   output logic             o_almost_full,
   output logic             o_almost_empty
);

   localparam int AW = clog2(DEPTH);
   localparam int PW = ptr_width(DEPTH);
   localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
   localparam logic [LW-1:0] AF_L    = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_L    = LW'(AE_THRESH);

   if (!is_pow2(DEPTH) || DEPTH < 4 || DEPTH > 1024) begin : g_bad_depth
      $error("ct_sync_fifo: DEPTH must be a power of two in 4..1024");
   end
   if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
      $error("ct_sync_fifo: AF_THRESH out of range 1..DEPTH");
   end
   if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
      $error("ct_sync_fifo: AE_THRESH out of range 0..DEPTH-1");
   end

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] ram_cnt;
   logic [LW-1:0] level_nxt;
   logic          push;
   logic          pop;
   logic          refill;
   logic          ram_we;
   logic          ram_re;

   assign push    = i_valid && o_ready;
   assign pop     = o_valid && i_ready;
   assign ram_cnt = wr_ptr - rd_ptr;
   // The RAM read register is the output register, so a refill is just a RAM read.
   assign refill  = (ram_cnt != '0) && (!o_valid || pop);
   assign ram_we  = push && !reset && !i_flush;
   assign ram_re  = refill && !reset && !i_flush;

   always_comb begin
      level_nxt = o_level;
      case ({push, pop})
         2'b10:   level_nxt = o_level + LW'(1);
         2'b01:   level_nxt = o_level - LW'(1);
         default: level_nxt = o_level;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         o_valid        <= 1'b0;
         o_ready        <= 1'b0;
         o_level        <= '0;
         o_almost_full  <= 1'b0;
         o_almost_empty <= 1'b1;
      end else if (i_flush) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         o_valid        <= 1'b0;
         o_ready        <= 1'b1;
         o_level        <= '0;
         o_almost_full  <= 1'b0;
         o_almost_empty <= 1'b1;
      end else begin
         if (push)   wr_ptr <= wr_ptr + PW'(1);
         if (refill) rd_ptr <= rd_ptr + PW'(1);
         o_valid        <= refill || (o_valid && !i_ready);
         o_level        <= level_nxt;
         o_ready        <= (level_nxt != DEPTH_L);
         o_almost_full  <= (level_nxt >= AF_L);
         o_almost_empty <= (level_nxt <= AE_L);
      end
   end

   ct_fifo_ram #(
      .WIDTH    (WIDTH),
      .DEPTH    (DEPTH),
      .RAMSTYLE (RAMSTYLE)
   ) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (i_data),
      .re    (ram_re),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (o_data)
   );

endmodule

// File: doc/ct_sync_fifo.md
CT_SYNC_FIFO -- requirements
Module: ct_sync_fifo

Interface
REQ-001 Parameter WIDTH, default 1, data bits per word.
REQ-002 Parameter DEPTH, default 32, total word capacity; power of two, 4..1024.
REQ-003 Parameter AF_THRESH, default 28, almost-full level threshold; 1..DEPTH.
REQ-004 Parameter AE_THRESH, default 4, almost-empty level threshold; 0..DEPTH-1.
REQ-005 Parameter RAMSTYLE, default "MLAB", RAM style attribute passed to storage.
REQ-006 clk  in  1  sole clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 i_flush  in  1  synchronous discard of all contents.
REQ-009 i_data  in  WIDTH  write data.
REQ-010 i_valid  in  1  write request.
REQ-011 o_ready  out  1  FIFO can accept a word.
REQ-012 o_data  out  WIDTH  head-of-queue data.
REQ-013 o_valid  out  1  o_data holds a valid word.
REQ-014 i_ready  in  1  downstream accepts o_data.
REQ-015 o_level  out  clog2(DEPTH)+1  occupancy (RAM plus output register).
REQ-016 o_almost_full  out  1  o_level >= AF_THRESH.
REQ-017 o_almost_empty  out  1  o_level <= AE_THRESH.

Function
REQ-018 Push occurs on an edge where i_valid && o_ready; pop occurs where o_valid && i_ready.
REQ-019 o_ready is registered: o_ready = (o_level != DEPTH) for the coming cycle; no push at full, even with a simultaneous pop.
REQ-020 o_valid is registered; o_data/o_valid hold stable while o_valid && !i_ready.
REQ-021 Into an empty FIFO, a word pushed on edge k appears with o_valid=1 after edge k+1.
REQ-022 Output register refills from RAM on any edge where it is empty or popped and RAM is non-empty; back-to-back pops sustain one word per cycle.
REQ-023 Words emerge in push order; no loss or duplication.
REQ-024 o_level: +1 on push only, -1 on pop only, unchanged on both or neither; never exceeds DEPTH or goes below 0.
REQ-025 o_almost_full/o_almost_empty are registered and consistent with o_level in the same cycle.
REQ-026 RAM pointers are clog2(DEPTH)+1 bits binary and wrap modulo 2*DEPTH; MSB distinguishes full from empty.
REQ-027 i_flush: next cycle o_valid=0, o_level=0, o_ready=1, pointers equal; a push coinciding with i_flush is discarded.
REQ-028 Simultaneous push and pop at level 1 with o_valid=1: the popped word leaves, the new word becomes valid one cycle later per REQ-021.

Reset
REQ-029 reset=1 on an edge sets o_valid=0, o_ready=0, o_level=0, o_almost_full=0, o_almost_empty=1, pointers=0.
REQ-030 o_ready rises to 1 on the first edge after reset deasserts; reset mid-operation discards all contents.
REQ-031 RAM contents and o_data are not reset; o_data is don't-care while o_valid=0.

Structure
REQ-032 Package ct_fifo_pkg holds a clog2 constant function and the level/pointer width derivations shared with future FIFO variants.
REQ-033 Storage is sub-module ct_fifo_ram: simple dual-port, synchronous write, synchronous read, no read-during-write check, RAMSTYLE applied.
REQ-034 Elaboration fails if DEPTH is not a power of two or the thresholds are out of range.

Verification
REQ-035 Reset, then a single push of 0x1 at edge k -> o_valid=1 and o_data=0x1 after edge k+1; o_level=1.
REQ-036 DEPTH=32, i_ready=0, continuous pushes -> 32 accepted, o_ready=0 with o_level=32; o_almost_full=1 from level 28.
REQ-037 With the FIFO full, i_valid=1 and i_ready=1 on the same edge -> pop only, no push; level becomes 31, then o_ready=1.
REQ-038 Stream 200 incrementing words, random i_valid/i_ready at 50% -> output is exactly 0..199 in order; the 2*DEPTH pointer wrap is exercised.
REQ-039 At level 10, assert i_flush together with a push -> next cycle o_level=0, o_valid=0, o_almost_empty=1; the pushed word never appears.
REQ-040 Continuous push and pop at steady state -> one word per cycle throughput; o_level constant.
